qdi_1of2_sync_rx: RTL and testbench

QDI_1OF2_SYNC_RX -- requirements
Module: qdi_1of2_sync_rx

---
 rtl/qdi_1of2_sync_rx.sv | 236 +++++++++++++++++++++++
 tb/tb_qdi_1of2_sync_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/qdi_1of2_sync_rx.sv
// qdi_1of2_sync_rx
// Receives e1of2 tokens from an asynchronous (QDI) upstream FIFO into the CLK
// domain. Each data rail is brought in through its own flop chain. A
// three-state handshake FSM drives the e1of2 enable (Rxe) and pushes accepted
// bits into a small registered FIFO that feeds a valid/ready consumer.
// The block also counts accepted tokens and keeps a sticky flag that is set
// when both rails are seen high at the same time.

module qdi_1of2_sync_rx #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [1:0]               Rx,
   output logic                     Rxe,
   output logic                     data_out,
   output logic                     valid_out,
   input  logic                     ready_in,
   output logic [CNT_W-1:0]         tok_count,
   output logic                     err_illegal,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);

   localparam logic [AW:0]      FULL_LVL = DEPTH[AW:0];
   localparam logic [AW:0]      LVL_ONE  = 1;
   localparam logic [AW-1:0]    PTR_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;

   typedef enum logic [1:0] {
      HOLD         = 2'd0,
      WAIT_VALID   = 2'd1,
      WAIT_NEUTRAL = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Reset release synchronizer
   // ------------------------------------------------------------------
   // Its length matches the rail synchronizers, so the rails already carry
   // real samples when the FSM is released. Without this, the FSM could
   // mistake the cleared pipeline for a neutral upstream.
   logic [SYNC_STAGES-1:0] rst_sync_q;
   logic [SYNC_STAGES-1:0] rst_sync_d;
   logic                   rst_ok;

   // Shift ones in behind the reset release
   always_comb begin
      rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
   end

   // Reset release register chain
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= rst_sync_d;
      end
   end

   assign rst_ok = rst_sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Rail synchronizers
   // ------------------------------------------------------------------
   logic [1:0] sync_q [SYNC_STAGES];
   logic [1:0] sync_d [SYNC_STAGES];
   logic [1:0] srx;

   // Next value of each synchronizer stage
   always_comb begin
      sync_d[0] = Rx;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // Rail synchronizer flops
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q <= sync_d;
      end
   end

   assign srx = sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Output buffer state
   // ------------------------------------------------------------------
   logic            mem_q [DEPTH];
   logic            mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     level_q,  level_d;
   logic [AW:0]     level_after_pop;
   logic            push;
   logic            pop;

   // ------------------------------------------------------------------
   // Handshake FSM
   // ------------------------------------------------------------------
   state_t           state_q, state_d;
   logic             rxe_q,   rxe_d;
   logic             err_q,   err_d;
   logic [CNT_W-1:0] tok_count_q, tok_count_d;

   assign valid_out       = (level_q != '0);
   assign pop             = valid_out & ready_in;
   assign level_after_pop = pop ? (level_q - LVL_ONE) : level_q;

   // Next-state, push decision and sticky error flag
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      err_d   = err_q;
      if (!rst_ok) begin
         state_d = HOLD;
      end else begin
         unique case (state_q)
            HOLD: begin
               if ((level_q < FULL_LVL) && (srx == 2'b00)) begin
                  state_d = WAIT_VALID;
               end
            end
            WAIT_VALID: begin
               unique case (srx)
                  2'b01, 2'b10: begin
                     push    = 1'b1;
                     state_d = WAIT_NEUTRAL;
                  end
                  2'b11: begin
                     err_d = 1'b1;
                  end
                  default: begin
                     state_d = WAIT_VALID;
                  end
               endcase
            end
            WAIT_NEUTRAL: begin
               if (srx == 2'b00) begin
                  // No push happens in this state, so occupancy after a
                  // same-edge pop decides whether there is room to re-enable.
                  if (level_after_pop < FULL_LVL) begin
                     state_d = WAIT_VALID;
                  end else begin
                     state_d = HOLD;
                  end
               end
            end
            default: begin
               state_d = HOLD;
            end
         endcase
      end
      rxe_d = (state_d == WAIT_VALID);
   end

   // Accepted-token counter, wraps naturally at 2^CNT_W
   always_comb begin
      tok_count_d = tok_count_q;
      if (push) begin
         tok_count_d = tok_count_q + CNT_ONE;
      end
   end

   // FSM state, registered enable, counter and error flag
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= HOLD;
         rxe_q       <= 1'b0;
         err_q       <= 1'b0;
         tok_count_q <= '0;
      end else begin
         state_q     <= state_d;
         rxe_q       <= rxe_d;
         err_q       <= err_d;
         tok_count_q <= tok_count_d;
      end
   end

   // ------------------------------------------------------------------
   // Registered FIFO
   // ------------------------------------------------------------------
   // Buffer write, pointer advance and occupancy update
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         mem_d[wr_ptr_q] = srx[1];
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({push, pop})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
   end

   // Buffer storage and pointers
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 1'b0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign Rxe         = rxe_q;
   assign data_out    = valid_out ? mem_q[rd_ptr_q] : 1'b0;
   assign tok_count   = tok_count_q;
   assign err_illegal = err_q;
   assign level       = level_q;

endmodule

// File: tb/tb_qdi_1of2_sync_rx.sv
// Directed bench for qdi_1of2_sync_rx. It models the upstream e1of2 sender
// and a downstream consumer, and keeps a scoreboard of the bits that were
// handed to the receiver.
// A second instance with a 4-bit counter shares every stimulus signal, so
// the two instances behave identically except for counter wrap.

module tb_qdi_1of2_sync_rx;

   localparam int S = 2;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [1:0]  Rx;
   logic        ready_in;

   logic        Rxe, data_out, valid_out, err_illegal;
   logic [15:0] tok_count;
   logic [2:0]  level;

   logic        rxe4, d4, v4, e4;
   logic [3:0]  tc4;
   logic [2:0]  lv4;

   int checks   = 0;
   int failures = 0;
   bit mon_en   = 1'b0;
   bit exp_q[$];

   qdi_1of2_sync_rx #(.DEPTH(4), .CNT_W(16), .SYNC_STAGES(S)) dut (
      .CLK(CLK), .RESET(RESET), .Rx(Rx), .Rxe(Rxe), .data_out(data_out),
      .valid_out(valid_out), .ready_in(ready_in), .tok_count(tok_count),
      .err_illegal(err_illegal), .level(level)
   );

   qdi_1of2_sync_rx #(.DEPTH(4), .CNT_W(4), .SYNC_STAGES(S)) dut_w4 (
      .CLK(CLK), .RESET(RESET), .Rx(Rx), .Rxe(rxe4), .data_out(d4),
      .valid_out(v4), .ready_in(ready_in), .tok_count(tc4),
      .err_illegal(e4), .level(lv4)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_rxe(input logic val, input string tag);
      for (int i = 0; i < 200; i++) begin
         if (Rxe === val) break;
         tick();
      end
      check(tag, Rxe, val);
   endtask

   // Place a token on the rails and wait for the acknowledge
   task automatic drive_token(input bit b);
      wait_rxe(1'b1, "rxe_ready");
      Rx = b ? 2'b10 : 2'b01;
      exp_q.push_back(b);
      wait_rxe(1'b0, "rxe_ack");
   endtask

   task automatic send_token(input bit b);
      drive_token(b);
      Rx = 2'b00;
   endtask

   task automatic do_reset();
      RESET = 1'b0;
      exp_q.delete();
      tick();
      tick();
      RESET = 1'b1;
   endtask

   // Consumer side: compare every popped bit against the scoreboard
   always @(negedge CLK) begin
      if (mon_en) begin
         if (valid_out) begin
            if (ready_in) begin
               check("sb_nonempty", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  check("data_out", data_out, exp_q.pop_front());
               end
            end
         end else begin
            check("data_idle_zero", data_out, 0);
         end
      end
   end

   initial begin
      int  cnt;
      bit  rxe_seen;

      RESET    = 1'b0;
      Rx       = 2'b00;
      ready_in = 1'b1;
      tick();
      tick();
      tick();

      // Reset state
      check("rst_rxe",   Rxe,         0);
      check("rst_level", level,       0);
      check("rst_valid", valid_out,   0);
      check("rst_data",  data_out,    0);
      check("rst_tok",   tok_count,   0);
      check("rst_err",   err_illegal, 0);
      mon_en = 1'b1;

      // Enable rises shortly after release with neutral rails
      RESET = 1'b1;
      cnt   = 0;
      while (!Rxe && cnt < 20) begin
         tick();
         cnt++;
      end
      check("rxe_rise_latency", cnt <= S + 2, 1);
      check("idle_level", level,     0);
      check("idle_valid", valid_out, 0);

      // Tokens 1,0,1 straight through
      send_token(1'b1);
      send_token(1'b0);
      send_token(1'b1);
      repeat (10) tick();
      check("seq_tok",   tok_count,    3);
      check("seq_level", level,        0);
      check("seq_drain", exp_q.size(), 0);

      // Back-pressure: buffer fills at 4, fifth waits for space
      do_reset();
      ready_in = 1'b0;
      send_token(1'b1);
      send_token(1'b1);
      send_token(1'b0);
      send_token(1'b1);
      repeat (10) tick();
      check("full_level", level,     4);
      check("full_rxe",   Rxe,       0);
      check("full_valid", valid_out, 1);
      check("full_tok",   tok_count, 4);
      ready_in = 1'b1;
      send_token(1'b0);
      repeat (12) tick();
      check("bp_tok",   tok_count,    5);
      check("bp_level", level,        0);
      check("bp_drain", exp_q.size(), 0);

      // Both rails high: flagged, nothing accepted, enable stays up
      wait_rxe(1'b1, "rxe_before_illegal");
      Rx = 2'b11;
      repeat (8) tick();
      check("ill_err", err_illegal, 1);
      check("ill_tok", tok_count,   5);
      check("ill_rxe", Rxe,         1);
      check("ill_lvl", level,       0);
      Rx = 2'b00;
      repeat (4) tick();
      send_token(1'b0);
      repeat (8) tick();
      check("post_ill_tok",   tok_count,   6);
      check("post_ill_err",   err_illegal, 1);
      check("post_ill_level", level,       0);

      // Reset mid-handshake with two tokens buffered and the rails held
      do_reset();
      ready_in = 1'b0;
      send_token(1'b1);
      drive_token(1'b0);
      check("pre_rst_level", level, 2);
      check("pre_rst_rxe",   Rxe,   0);
      RESET = 1'b0;
      exp_q.delete();
      #1;
      check("mid_rst_level", level,       0);
      check("mid_rst_valid", valid_out,   0);
      check("mid_rst_tok",   tok_count,   0);
      check("mid_rst_rxe",   Rxe,         0);
      check("mid_rst_err",   err_illegal, 0);
      tick();
      tick();
      RESET    = 1'b1;
      rxe_seen = 1'b0;
      repeat (10) begin
         tick();
         if (Rxe) rxe_seen = 1'b1;
      end
      check("rxe_held_nonneutral", rxe_seen, 0);
      Rx = 2'b00;
      wait_rxe(1'b1, "rxe_after_neutral");
      check("post_rst_level", level, 0);
      ready_in = 1'b1;

      // Counter wrap on the 4-bit instance
      do_reset();
      for (int i = 0; i < 17; i++) begin
         send_token(bit'(i % 2));
      end
      repeat (10) tick();
      check("wrap_tok16", tok_count,    17);
      check("wrap_tok4",  tc4,          1);
      check("wrap_level", level,        0);
      check("wrap_drain", exp_q.size(), 0);
      check("w4_level",   lv4,          0);
      check("w4_valid",   v4,           0);
      check("w4_data",    d4,           0);
      check("w4_err",     e4,           0);
      check("w4_rxe",     rxe4,         1);

      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
